// File: rtl/shift_pipe_n.sv
// shift_pipe_n: WIDTH-bit, DEPTH-stage register pipeline with per-stage valid
// bits and a registered occupancy counter. mode=0 shifts one stage per enabled
// edge (PIPE); mode=1 loads every stage from the input at once (BROADCAST).
// Optional macro SHIFT_PIPE_TAP_EN exposes every stage on taps/tap_valid.
module shift_pipe_n #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   en,
  input  logic                   mode,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [CNT_W-1:0]       fill_cnt,
  output logic                   full
`ifdef SHIFT_PIPE_TAP_EN
  ,
  output logic [WIDTH*DEPTH-1:0] taps,
  output logic [DEPTH-1:0]       tap_valid
`endif
);

  // A pipeline needs at least two stages and a non-empty data word.
  if (DEPTH < 2 || WIDTH < 1) begin : g_badParams
    $error("shift_pipe_n: DEPTH must be >= 2 and WIDTH must be >= 1");
  end

  logic [WIDTH-1:0] r_stage [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [CNT_W-1:0] r_fillCnt;
  logic             r_full;
  logic [CNT_W-1:0] w_nextCnt;

  // Next occupancy: tracks the valid bits entering and leaving the chain.
  always_comb begin
    w_nextCnt = r_fillCnt;
    if (flush) begin
      w_nextCnt = '0;
    end else if (en) begin
      if (mode) begin
        w_nextCnt = in_valid ? CNT_W'(DEPTH) : '0;
      end else begin
        w_nextCnt = r_fillCnt + CNT_W'(in_valid) - CNT_W'(r_valid[DEPTH-1]);
      end
    end
  end

  // Data and valid stages: flush beats enable; PIPE shifts, BROADCAST loads all.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
      r_valid <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
      r_valid <= '0;
    end else if (en) begin
      if (mode) begin
        for (int i = 0; i < DEPTH; i++) begin
          r_stage[i] <= in_data;
        end
        r_valid <= {DEPTH{in_valid}};
      end else begin
        r_stage[0] <= in_data;
        for (int i = 1; i < DEPTH; i++) begin
          r_stage[i] <= r_stage[i-1];
        end
        r_valid <= {r_valid[DEPTH-2:0], in_valid};
      end
    end
  end

  // Occupancy counter and full flag, updated on the same edge as the valid bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fillCnt <= '0;
      r_full    <= 1'b0;
    end else begin
      r_fillCnt <= w_nextCnt;
      r_full    <= (w_nextCnt == CNT_W'(DEPTH));
    end
  end

  assign out_valid = r_valid[DEPTH-1];
  assign out_data  = r_stage[DEPTH-1];
  assign fill_cnt  = r_fillCnt;
  assign full      = r_full;

`ifdef SHIFT_PIPE_TAP_EN
  for (genvar g = 0; g < DEPTH; g++) begin : g_taps
    assign taps[g*WIDTH +: WIDTH] = r_stage[g];
  end
  assign tap_valid = r_valid;
`endif

endmodule

// File: doc/shift_pipe_n.md
Name: shift_pipe_n

Overview:
Parametrised multi-stage register pipeline with per-stage valid tracking and an occupancy counter. It generalises the two-stage registered chain to WIDTH bits and DEPTH stages, with a runtime mode select:
- PIPE: true shift, DEPTH-cycle latency.
- BROADCAST: all stages loaded in the same cycle, 1-cycle latency.
Used as a configurable delay/alignment line in datapaths and as the standard demo of non-blocking versus blocking-equivalent update order.

Parameters:
WIDTH, 8, data width of each stage in bits (>=1)
DEPTH, 4, number of stages (>=2)
CNT_W, $clog2(DEPTH+1), width of fill_cnt; derived, not to be overridden

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
en  input  1  advance enable; 0 = hold all state
mode  input  1  0 = PIPE, 1 = BROADCAST; sampled at each edge
flush  input  1  synchronous clear of all stages; overrides en
in_valid  input  1  qualifies in_data
in_data  input  WIDTH  data into stage 0
out_valid  output  1  valid bit of stage DEPTH-1
out_data  output  WIDTH  data of stage DEPTH-1
fill_cnt  output  CNT_W  number of stages holding valid data, 0..DEPTH
full  output  1  fill_cnt == DEPTH

Behaviour:
- State: data stages s[0..DEPTH-1] (WIDTH bits each) and valid bits v[0..DEPTH-1]. All outputs come directly from registers; there is no combinational path from input to output.
- Reset (reset_n=0): takes effect immediately, independent of clk. All s=0, v=0, fill_cnt=0, full=0, out_valid=0, out_data=0. Reset asserted mid-operation discards all in-flight data. First update occurs on the first rising edge after reset_n is released.
- Update priority at each rising edge: flush > en.
- flush=1: all s cleared to 0, all v cleared to 0, fill_cnt=0. en, mode and inputs are ignored for that edge.
- en=0 and flush=0: all state holds, including fill_cnt.
- en=1, mode=0 (PIPE):
  - s[0]<=in_data, v[0]<=in_valid.
  - s[i]<=s[i-1] and v[i]<=v[i-1] for i in 1..DEPTH-1.
  - All stages update from their pre-edge values (non-blocking semantics).
  - Latency from in_data sampled to out_data is exactly DEPTH enabled edges.
  - The stage DEPTH-1 value is discarded at each enabled edge.
- en=1, mode=1 (BROADCAST):
  - Every s[i]<=in_data and every v[i]<=in_valid (blocking-chain equivalent).
  - Latency is 1 edge.
- Data is captured into stages regardless of in_valid; v marks which stages hold valid data. Bench checks compare out_data only when out_valid=1.
- fill_cnt is a registered counter, updated on the same edge as v:
  - PIPE: fill_cnt + in_valid - v[DEPTH-1] (pre-edge values). Cannot overflow or underflow by construction.
  - BROADCAST: DEPTH if in_valid=1, else 0.
  - Invariant: fill_cnt always equals the popcount of v. The bench asserts this every cycle.
- full is registered, or derived from registered fill_cnt; either way it must be valid in the same cycle as fill_cnt.
- Mode change mid-stream takes effect at the edge where the new mode is sampled. Switching PIPE->BROADCAST overwrites all stages. Switching BROADCAST->PIPE shifts from the broadcast contents.
- Simultaneous flush and en=1 with in_valid=1: flush wins and the input is dropped.
- DEPTH < 2 or WIDTH < 1: elaboration error via a generate-time check.

Optional Feature:
Macro SHIFT_PIPE_TAP_EN.
- Defined: adds output port taps [WIDTH*DEPTH-1:0], where taps[i*WIDTH +: WIDTH] = s[i]. Also adds output tap_valid [DEPTH-1:0] = v. Both are straight from registers and reset to 0.
- Undefined: neither port exists, and core behaviour is otherwise identical.

Test Plan (all scenarios use WIDTH=8, DEPTH=4):
- Reset/hold: drive reset_n=0 mid-stream with fill_cnt=3 -> immediately out_valid=0, out_data=0x00, fill_cnt=0, without waiting for a clk edge. Release reset, then en=0 for 5 cycles -> state stays 0.
- PIPE latency: mode=0, en=1, in_valid=1, in_data 0x11,0x22,0x33,0x44,0x55 on consecutive edges -> out_data=0x11 with out_valid=1 after the 4th edge, then 0x22..0x55. fill_cnt goes 1,2,3,4; full=1 from the 4th edge.
- BROADCAST: mode=1, en=1, in_valid=1, in_data=0xA5 for one edge -> after that edge out_data=0xA5, out_valid=1, fill_cnt=4, full=1. Next edge with in_valid=0 -> fill_cnt=0, out_valid=0.
- Bubbles and stall: PIPE with in_valid pattern 1,0,1,1 and data 0x01..0x04 -> fill_cnt 1,1,2,3. Hold en=0 for 3 cycles -> outputs frozen. Resume -> out_valid sequence 1,0,1,1 carrying 0x01, -, 0x03, 0x04.
- Flush priority: pipeline full of 0x10..0x13, then flush=1 with en=1, in_valid=1, in_data=0xFF -> after the edge all v=0, fill_cnt=0, out_data=0x00, and 0xFF never appears.
- Mode switch and tap: fill PIPE with 0x01..0x04, then one BROADCAST edge with 0x77 -> all stages hold 0x77. With SHIFT_PIPE_TAP_EN defined, taps=0x77777777 and tap_valid=4'b1111.
